image_writeback: RTL and testbench

Streams filtered 8-bit pixels back into the single-port image RAM (address, clock, data, wren, q) that the median-filter path reads from, in raster order at linear addresses. It sits after the filter datapath. It accepts pixels over a valid/ready handshake, buffers them in a small FIFO, and issues RAM writes only when the shared-RAM arbiter grants the port. One `start` pulse writes one full WIDTH×HEIGHT frame.

---
 rtl/image_writeback.sv | 130 +++++++++++++
 tb/tb_image_writeback.sv | 443 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/image_writeback.sv
// Writes one WIDTH x HEIGHT frame of filtered pixels into the shared image RAM
// in raster order, buffering through a small FIFO while the arbiter withholds the port.
module image_writeback #(
   parameter int WIDTH      = 100,
   parameter int HEIGHT     = 100,
   parameter int DATA_W     = 8,
   parameter int ADDR_W     = 14,
   parameter int BASE_ADDR  = 0,
   parameter int FIFO_DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [DATA_W-1:0] pix_in,
   input  logic              pix_valid,
   output logic              pix_ready,
   input  logic              mem_grant,
   output logic [ADDR_W-1:0] address,
   output logic [DATA_W-1:0] data,
   output logic              wren,
   output logic [6:0]        x,
   output logic [6:0]        y,
   output logic              busy,
   output logic              done,
   output logic              drop_err
);

   localparam int TOTAL = WIDTH * HEIGHT;
   localparam int CNT_W = $clog2(TOTAL + 1);
   localparam int PTR_W = $clog2(FIFO_DEPTH);

   if (BASE_ADDR + TOTAL - 1 >= (1 << ADDR_W)) begin : g_addr_range
      $error("image_writeback: BASE_ADDR + WIDTH*HEIGHT - 1 does not fit in ADDR_W bits");
   end
   if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_fifo_depth
      $error("image_writeback: FIFO_DEPTH must be a power of two and at least 2");
   end
   if (WIDTH > 128 || HEIGHT > 127) begin : g_raster_range
      $error("image_writeback: x/y are 7 bits; WIDTH <= 128 and HEIGHT <= 127");
   end

   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

   state_t            state;
   logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [PTR_W:0]    fill;
   logic [CNT_W-1:0]  accept_cnt;
   logic [CNT_W-1:0]  write_cnt;
   logic              fifo_full;
   logic              fifo_empty;
   logic              push;
   logic              pop;

   // Handshake: a pixel transfers on every rising edge where pix_valid and
   // pix_ready are both high; pix_ready never depends on pix_valid.
   assign fifo_full  = (fill == (PTR_W + 1)'(FIFO_DEPTH));
   assign fifo_empty = (fill == '0);
   assign pix_ready  = (state == RUN) && !fifo_full && (accept_cnt < CNT_W'(TOTAL));
   assign push       = pix_valid && pix_ready;
   assign pop        = (state == RUN) && !fifo_empty && mem_grant;
   assign busy       = (state != IDLE);
   assign done       = (state == DONE);

   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr] <= pix_in;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fill       <= '0;
         accept_cnt <= '0;
         write_cnt  <= '0;
         address    <= '0;
         data       <= '0;
         wren       <= 1'b0;
         x          <= '0;
         y          <= '0;
         drop_err   <= 1'b0;
      end else begin
         wren <= 1'b0;
         if (pix_valid && state != RUN) drop_err <= 1'b1;
         case (state)
            IDLE: begin
               if (start) begin
                  state      <= RUN;
                  wr_ptr     <= '0;
                  rd_ptr     <= '0;
                  fill       <= '0;
                  accept_cnt <= '0;
                  write_cnt  <= '0;
                  x          <= '0;
                  y          <= '0;
                  drop_err   <= 1'b0;
               end
            end
            RUN: begin
               if (push) begin
                  wr_ptr     <= wr_ptr + 1'b1;
                  accept_cnt <= accept_cnt + 1'b1;
               end
               if (pop) begin
                  rd_ptr    <= rd_ptr + 1'b1;
                  wren      <= 1'b1;
                  data      <= fifo_mem[rd_ptr];
                  address   <= ADDR_W'(BASE_ADDR) + ADDR_W'(write_cnt);
                  write_cnt <= write_cnt + 1'b1;
                  if (x == 7'(WIDTH - 1)) begin
                     x <= '0;
                     y <= y + 1'b1;
                  end else begin
                     x <= x + 1'b1;
                  end
               end
               if (push && !pop) fill <= fill + 1'b1;
               else if (!push && pop) fill <= fill - 1'b1;
               // write_cnt reaches TOTAL in the cycle the last wren is visible.
               if (write_cnt == CNT_W'(TOTAL)) state <= DONE;
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_image_writeback.sv
// Bench for image_writeback: scoreboarded frame writes, grant stalls, drop_err,
// asynchronous reset mid-frame and ignored start pulses; a second instance uses BASE_ADDR=500.
module tb_image_writeback;

   localparam int W      = 100;
   localparam int H      = 100;
   localparam int TOTAL  = W * H;
   localparam int BASE_B = 500;
   localparam int DEPTH  = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [7:0]  pix_in;
   logic        pix_valid;
   logic        mem_grant;

   logic        pix_ready, wren, busy, done, drop_err;
   logic [13:0] address;
   logic [7:0]  data;
   logic [6:0]  x, y;

   logic        pix_ready_b, wren_b, busy_b, done_b, drop_err_b;
   logic [13:0] address_b;
   logic [7:0]  data_b;
   logic [6:0]  x_b, y_b;

   image_writeback #(.WIDTH(W), .HEIGHT(H), .DATA_W(8), .ADDR_W(14), .BASE_ADDR(0),
                     .FIFO_DEPTH(DEPTH)) u_dut (
      .clk(clk), .rst(rst), .start(start), .pix_in(pix_in), .pix_valid(pix_valid),
      .pix_ready(pix_ready), .mem_grant(mem_grant), .address(address), .data(data),
      .wren(wren), .x(x), .y(y), .busy(busy), .done(done), .drop_err(drop_err)
   );

   image_writeback #(.WIDTH(W), .HEIGHT(H), .DATA_W(8), .ADDR_W(14), .BASE_ADDR(BASE_B),
                     .FIFO_DEPTH(DEPTH)) u_dut_b (
      .clk(clk), .rst(rst), .start(start), .pix_in(pix_in), .pix_valid(pix_valid),
      .pix_ready(pix_ready_b), .mem_grant(mem_grant), .address(address_b), .data(data_b),
      .wren(wren_b), .x(x_b), .y(y_b), .busy(busy_b), .done(done_b), .drop_err(drop_err_b)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int         errors = 0;
   int         checks = 0;
   logic [7:0] exp_q[$];
   logic [7:0] ram [16384];
   logic [7:0] exp_d;
   int         wr_idx = 0;
   int         wren_cnt = 0;
   int         done_cnt = 0;
   int         run_len = 0;
   int         max_run = 0;
   int         first_wren_cyc = 0;
   int         last_addr_b = 0;
   int         idx = 0;
   int         mon_nx, mon_ny;

   // Scoreboard: accepted pixels are queued; every wren pops one and checks
   // address, data and the raster position of the next pixel.
   always @(negedge clk) begin
      if (!rst) begin
         if (wren) begin
            wren_cnt++;
            run_len++;
            if (run_len > max_run) max_run = run_len;
            if (wren_cnt == 1) first_wren_cyc = cyc;
            mon_nx = (wr_idx + 1) % W;
            mon_ny = (wr_idx + 1) / W;
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_wren address=%0d data=%0d", address, data);
            end else begin
               exp_d = exp_q.pop_front();
               if (address !== 14'(wr_idx) || data !== exp_d || x !== 7'(mon_nx) || y !== 7'(mon_ny)) begin
                  errors++;
                  $display("FAIL write_%0d got addr=%0d data=%0d x=%0d y=%0d expected addr=%0d data=%0d x=%0d y=%0d",
                           wr_idx, address, data, x, y, wr_idx, exp_d, mon_nx, mon_ny);
               end
            end
            ram[address] = data;
            checks++;
            if (address_b !== 14'(BASE_B + wr_idx)) begin
               errors++;
               $display("FAIL base_addr_write_%0d got %0d expected %0d", wr_idx, address_b, BASE_B + wr_idx);
            end
            last_addr_b = int'(address_b);
            wr_idx++;
         end else begin
            run_len = 0;
         end
         if (done) done_cnt++;
         checks++;
         if ({pix_ready_b, wren_b, data_b, x_b, y_b, busy_b, done_b, drop_err_b} !==
             {pix_ready, wren, data, x, y, busy, done, drop_err}) begin
            errors++;
            $display("FAIL base_instance_mirror cyc=%0d got %h expected %h", cyc,
                     {pix_ready_b, wren_b, data_b, x_b, y_b, busy_b, done_b, drop_err_b},
                     {pix_ready, wren, data, x, y, busy, done, drop_err});
         end
         if (pix_valid && pix_ready) exp_q.push_back(pix_in);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_frame();
      exp_q.delete();
      wr_idx   = 0;
      wren_cnt = 0;
      done_cnt = 0;
      run_len  = 0;
      max_run  = 0;
      idx      = 0;
      for (int a = 0; a < 16384; a++) ram[a] = 'x;
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic drive_pixels(input int upto, input bit rnd, output int ncyc);
      bit acc;
      ncyc = 0;
      while (idx < upto && ncyc < 8 * TOTAL) begin
         pix_in    = idx[7:0];
         pix_valid = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
         if (rnd) mem_grant = ($urandom_range(0, 4) != 0);
         acc = pix_valid && pix_ready;
         tick();
         ncyc++;
         if (acc) idx++;
      end
      pix_valid = 1'b0;
   endtask

   task automatic wait_writes(input int n);
      for (int i = 0; i < 2000 && wren_cnt < n; i++) tick();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) tick();
      checks++;
      if ({pix_ready, wren, busy, done, drop_err} !== 5'b0) begin
         errors++;
         $display("FAIL reset_flags got %b expected 00000", {pix_ready, wren, busy, done, drop_err});
      end
      checks++;
      if (address !== 14'd0 || data !== 8'd0) begin
         errors++;
         $display("FAIL reset_addr_data got addr=%0d data=%0d expected 0 0", address, data);
      end
      checks++;
      if (x !== 7'd0 || y !== 7'd0) begin
         errors++;
         $display("FAIL reset_xy got x=%0d y=%0d expected 0 0", x, y);
      end
      rst = 1'b0;
      repeat (2) tick();
      checks++;
      if (busy !== 1'b0 || pix_ready !== 1'b0) begin
         errors++;
         $display("FAIL idle_after_reset got busy=%b ready=%b expected 0 0", busy, pix_ready);
      end
   endtask

   task automatic test_back_to_back();
      int n, acc_cyc, bad;
      mem_grant = 1'b1;
      start_frame();
      checks++;
      if (busy !== 1'b1 || pix_ready !== 1'b1) begin
         errors++;
         $display("FAIL start_latency got busy=%b ready=%b expected 1 1", busy, pix_ready);
      end
      acc_cyc = cyc;
      drive_pixels(TOTAL, 1'b0, n);
      checks++;
      if (n != TOTAL) begin
         errors++;
         $display("FAIL throughput got %0d cycles expected %0d", n, TOTAL);
      end
      wait_writes(TOTAL);
      checks++;
      if (wren_cnt != TOTAL) begin
         errors++;
         $display("FAIL b2b_write_count got %0d expected %0d", wren_cnt, TOTAL);
      end
      checks++;
      if (done !== 1'b1 || busy !== 1'b1) begin
         errors++;
         $display("FAIL done_after_last_write got done=%b busy=%b expected 1 1", done, busy);
      end
      checks++;
      if (first_wren_cyc != acc_cyc + 2) begin
         errors++;
         $display("FAIL first_write_latency got cycle %0d expected %0d", first_wren_cyc, acc_cyc + 2);
      end
      tick();
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL idle_after_done got done=%b busy=%b expected 0 0", done, busy);
      end
      repeat (3) tick();
      checks++;
      if (done_cnt != 1) begin
         errors++;
         $display("FAIL b2b_done_pulses got %0d expected 1", done_cnt);
      end
      checks++;
      if (max_run != TOTAL) begin
         errors++;
         $display("FAIL consecutive_wren got %0d expected %0d", max_run, TOTAL);
      end
      checks++;
      if (x !== 7'd0 || y !== 7'(H)) begin
         errors++;
         $display("FAIL final_raster got x=%0d y=%0d expected 0 %0d", x, y, H);
      end
      checks++;
      if (last_addr_b != BASE_B + TOTAL - 1) begin
         errors++;
         $display("FAIL base_last_addr got %0d expected %0d", last_addr_b, BASE_B + TOTAL - 1);
      end
      bad = 0;
      for (int a = 0; a < TOTAL; a++) if (ram[a] !== 8'(a % 256)) bad++;
      checks++;
      if (bad != 0 || exp_q.size() != 0) begin
         errors++;
         $display("FAIL b2b_ram_contents got %0d bad words, %0d pending expected 0 0", bad, exp_q.size());
      end
   endtask

   task automatic test_grant_stall();
      int n, w1, bad;
      bit acc;
      mem_grant = 1'b1;
      start_frame();
      drive_pixels(3000, 1'b0, n);
      mem_grant = 1'b0;
      w1 = 0;
      for (int i = 0; i < 20; i++) begin
         pix_in    = idx[7:0];
         pix_valid = 1'b1;
         acc       = pix_ready;
         if (i == 1) w1 = wren_cnt;
         tick();
         if (acc) idx++;
      end
      checks++;
      if (pix_ready !== 1'b0) begin
         errors++;
         $display("FAIL stall_ready got %b expected 0", pix_ready);
      end
      checks++;
      if (exp_q.size() != DEPTH) begin
         errors++;
         $display("FAIL stall_buffered got %0d expected %0d", exp_q.size(), DEPTH);
      end
      checks++;
      if (wren_cnt != w1) begin
         errors++;
         $display("FAIL stall_no_write got %0d writes expected %0d", wren_cnt, w1);
      end
      pix_valid = 1'b0;
      mem_grant = 1'b1;
      drive_pixels(TOTAL, 1'b1, n);
      mem_grant = 1'b1;
      wait_writes(TOTAL);
      repeat (3) tick();
      checks++;
      if (wren_cnt != TOTAL || done_cnt != 1 || exp_q.size() != 0) begin
         errors++;
         $display("FAIL stall_frame got writes=%0d done=%0d pending=%0d expected %0d 1 0",
                  wren_cnt, done_cnt, exp_q.size(), TOTAL);
      end
      bad = 0;
      for (int a = 0; a < TOTAL; a++) if (ram[a] !== 8'(a % 256)) bad++;
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL stall_ram_contents got %0d bad words expected 0", bad);
      end
   endtask

   task automatic test_drop_err();
      int n;
      pix_valid = 1'b1;
      checks++;
      if (pix_ready !== 1'b0) begin
         errors++;
         $display("FAIL idle_ready got %b expected 0", pix_ready);
      end
      tick();
      pix_valid = 1'b0;
      checks++;
      if (drop_err !== 1'b1) begin
         errors++;
         $display("FAIL drop_set got %b expected 1", drop_err);
      end
      repeat (3) tick();
      checks++;
      if (drop_err !== 1'b1) begin
         errors++;
         $display("FAIL drop_sticky got %b expected 1", drop_err);
      end
      mem_grant = 1'b1;
      start_frame();
      checks++;
      if (drop_err !== 1'b0) begin
         errors++;
         $display("FAIL drop_clear_on_start got %b expected 0", drop_err);
      end
      drive_pixels(TOTAL, 1'b0, n);
      wait_writes(TOTAL);
      pix_valid = 1'b1;
      tick();
      pix_valid = 1'b0;
      checks++;
      if (drop_err !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL drop_in_done got drop=%b busy=%b expected 1 0", drop_err, busy);
      end
      repeat (2) tick();
      checks++;
      if (drop_err !== 1'b1) begin
         errors++;
         $display("FAIL drop_held_in_idle got %b expected 1", drop_err);
      end
   endtask

   task automatic test_reset_mid_frame();
      int n, w0;
      mem_grant = 1'b1;
      start_frame();
      checks++;
      if (drop_err !== 1'b0) begin
         errors++;
         $display("FAIL drop_clear_second_start got %b expected 0", drop_err);
      end
      drive_pixels(5002, 1'b0, n);
      wait_writes(5000);
      checks++;
      if (wren_cnt < 5000) begin
         errors++;
         $display("FAIL pre_reset_writes got %0d expected at least 5000", wren_cnt);
      end
      rst = 1'b1;
      #1;
      checks++;
      if ({pix_ready, wren, busy, done, drop_err, address, data, x, y} !== '0) begin
         errors++;
         $display("FAIL async_reset got %h expected 0",
                  {pix_ready, wren, busy, done, drop_err, address, data, x, y});
      end
      w0 = wren_cnt;
      repeat (3) tick();
      rst = 1'b0;
      repeat (5) tick();
      checks++;
      if (wren_cnt != w0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL after_reset_quiet got writes=%0d busy=%b expected %0d 0", wren_cnt, busy, w0);
      end
      start_frame();
      drive_pixels(TOTAL, 1'b0, n);
      wait_writes(TOTAL);
      repeat (3) tick();
      checks++;
      if (wren_cnt != TOTAL || done_cnt != 1 || exp_q.size() != 0) begin
         errors++;
         $display("FAIL rewrite_frame got writes=%0d done=%0d pending=%0d expected %0d 1 0",
                  wren_cnt, done_cnt, exp_q.size(), TOTAL);
      end
   endtask

   task automatic test_start_ignored();
      int n;
      mem_grant = 1'b1;
      start_frame();
      drive_pixels(2000, 1'b0, n);
      start = 1'b1;
      tick();
      start = 1'b0;
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL start_in_run_busy got %b expected 1", busy);
      end
      drive_pixels(TOTAL, 1'b0, n);
      wait_writes(TOTAL);
      checks++;
      if (wren_cnt != TOTAL || done !== 1'b1) begin
         errors++;
         $display("FAIL start_in_run_ignored got writes=%0d done=%b expected %0d 1", wren_cnt, done, TOTAL);
      end
      start = 1'b1;
      tick();
      start = 1'b0;
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL start_in_done_ignored got busy=%b expected 0", busy);
      end
      repeat (3) tick();
      checks++;
      if (busy !== 1'b0 || done_cnt != 1) begin
         errors++;
         $display("FAIL single_done_pulse got busy=%b done_pulses=%0d expected 0 1", busy, done_cnt);
      end
   endtask

   initial begin
      rst       = 1'b1;
      start     = 1'b0;
      pix_valid = 1'b0;
      pix_in    = 8'd0;
      mem_grant = 1'b0;
      test_reset();
      test_back_to_back();
      test_grant_stall();
      test_drop_err();
      test_reset_mid_frame();
      test_start_ignored();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #1500000;
      $display("FAIL watchdog simulation exceeded time limit at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

endmodule
